// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard interface: ID/EXE hazard fields in, pipeline register controls out.
// The master side is the pipeline datapath; the slave side is the stall controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic [4:0]       exe_dest;
  logic             exe_mem_r_en;
  logic [3:0]       exe_cmd;
  logic             br_taken;
  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_mem_r_en, exe_cmd, br_taken,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_hold, idex_flush, exmem_flush,
           mc_busy, stall_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_mem_r_en, exe_cmd, br_taken,
    output pc_freeze, ifid_freeze, ifid_flush, idex_hold, idex_flush, exmem_flush,
           mc_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch flushes and
// multicycle EXE holds, plus a saturating stalled-cycle counter.
module hazard_stall_ctrl #(
  parameter logic [3:0] MC_CMD = 4'hE,
  parameter int         MC_LAT = 4,
  parameter int         CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  // MC_LAT-2 remaining hold cycles after the first; unused when MC_LAT==1.
  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

  state_t           state_r;
  logic [3:0]       mc_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic mc_start_s;
  logic hold_s;
  logic lu_s;
  logic pc_freeze_s;
  logic ifid_freeze_s;
  logic ifid_flush_s;
  logic idex_hold_s;
  logic idex_flush_s;
  logic exmem_flush_s;
  logic mc_busy_s;

  // Hazard detection terms.
  always_comb begin
    mc_start_s = (state_r == ST_RUN) && (bus.exe_cmd == MC_CMD) && (MC_LAT > 1);
    hold_s     = mc_start_s || ((state_r == ST_MC_BUSY) && (mc_cnt_r != 4'd0));
    lu_s       = bus.exe_mem_r_en && (bus.exe_dest != 5'd0) &&
                 ((bus.exe_dest == bus.id_src1) ||
                  (bus.id_two_src && (bus.exe_dest == bus.id_src2)));
  end

  // Prioritised control decode; everything is forced low while in reset.
  always_comb begin
    pc_freeze_s   = 1'b0;
    ifid_freeze_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_hold_s   = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    mc_busy_s     = 1'b0;
    if (!rst_n) begin
      pc_freeze_s = 1'b0;
    end else if (hold_s) begin
      pc_freeze_s   = 1'b1;
      ifid_freeze_s = 1'b1;
      idex_hold_s   = 1'b1;
      exmem_flush_s = 1'b1;
      mc_busy_s     = 1'b1;
    end else if (bus.br_taken) begin
      // The ID instruction is on the wrong path, so a pending load-use stall is moot.
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (lu_s) begin
      pc_freeze_s   = 1'b1;
      ifid_freeze_s = 1'b1;
      idex_flush_s  = 1'b1;
    end else begin
      pc_freeze_s = 1'b0;
    end
  end

  // Multicycle sequencing FSM and stall performance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      mc_cnt_r    <= 4'd0;
      stall_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mc_start_s) begin
            state_r  <= ST_MC_BUSY;
            mc_cnt_r <= MC_INIT;
          end
        end
        ST_MC_BUSY: begin
          if (mc_cnt_r != 4'd0) begin
            mc_cnt_r <= mc_cnt_r - 4'd1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r  <= ST_RUN;
          mc_cnt_r <= 4'd0;
        end
      endcase
      if (pc_freeze_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign bus.pc_freeze   = pc_freeze_s;
  assign bus.ifid_freeze = ifid_freeze_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_hold   = idex_hold_s;
  assign bus.idex_flush  = idex_flush_s;
  assign bus.exmem_flush = exmem_flush_s;
  assign bus.mc_busy     = mc_busy_s;
  assign bus.stall_cnt   = stall_cnt_r;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: main instance plus a 2-bit-counter
// instance (saturation) and an MC_LAT=1 instance, all sharing one stimulus.
module tb_hazard_stall_ctrl;
  // Control vector order: pc_freeze, ifid_freeze, ifid_flush, idex_hold, idex_flush, exmem_flush, mc_busy
  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_HOLD = 7'b1101011;
  localparam logic [6:0] CTL_BR   = 7'b0010100;
  localparam logic [6:0] CTL_LU   = 7'b1100100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) a_if ();
  hazard_stall_ctrl_if #(.CNT_W(2))  b_if ();
  hazard_stall_ctrl_if #(.CNT_W(16)) c_if ();

  hazard_stall_ctrl #(.MC_CMD(4'hE), .MC_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  hazard_stall_ctrl #(.MC_CMD(4'hE), .MC_LAT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  hazard_stall_ctrl #(.MC_CMD(4'hE), .MC_LAT(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave));

  assign b_if.id_src1 = a_if.id_src1;       assign c_if.id_src1 = a_if.id_src1;
  assign b_if.id_src2 = a_if.id_src2;       assign c_if.id_src2 = a_if.id_src2;
  assign b_if.id_two_src = a_if.id_two_src; assign c_if.id_two_src = a_if.id_two_src;
  assign b_if.exe_dest = a_if.exe_dest;     assign c_if.exe_dest = a_if.exe_dest;
  assign b_if.exe_mem_r_en = a_if.exe_mem_r_en;
  assign c_if.exe_mem_r_en = a_if.exe_mem_r_en;
  assign b_if.exe_cmd = a_if.exe_cmd;       assign c_if.exe_cmd = a_if.exe_cmd;
  assign b_if.br_taken = a_if.br_taken;     assign c_if.br_taken = a_if.br_taken;

  logic [6:0] ctl_a;
  logic [6:0] ctl_c;
  assign ctl_a = {a_if.pc_freeze, a_if.ifid_freeze, a_if.ifid_flush, a_if.idex_hold,
                  a_if.idex_flush, a_if.exmem_flush, a_if.mc_busy};
  assign ctl_c = {c_if.pc_freeze, c_if.ifid_freeze, c_if.ifid_flush, c_if.idex_hold,
                  c_if.idex_flush, c_if.exmem_flush, c_if.mc_busy};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] src1, input logic [4:0] src2, input logic two,
                        input logic [4:0] dest, input logic ld, input logic [3:0] cmd,
                        input logic br);
    a_if.id_src1      = src1;
    a_if.id_src2      = src2;
    a_if.id_two_src   = two;
    a_if.exe_dest     = dest;
    a_if.exe_mem_r_en = ld;
    a_if.exe_cmd      = cmd;
    a_if.br_taken     = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: a live load-use condition must still produce no controls.
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 1'b0);
    tick(); tick();
    check_eq("reset_ctl", 32'(ctl_a), 32'(CTL_NONE));
    check_eq("reset_cnt", 32'(a_if.stall_cnt), 32'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1. load-use on src1: one bubble, then clear.
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 1'b0); #1;
    check_eq("lu_src1", 32'(ctl_a), 32'(CTL_LU));
    tick();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 4'h0, 1'b0); #1;
    check_eq("lu_after", 32'(ctl_a), 32'(CTL_NONE));
    check_eq("lu_cnt1", 32'(a_if.stall_cnt), 32'd1);
    tick();

    // 2. src2 without id_two_src, dest r0, then src2 with id_two_src.
    set_in(5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 4'h0, 1'b0); #1;
    check_eq("lu_src2_notwo", 32'(ctl_a), 32'(CTL_NONE));
    tick();
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 4'h0, 1'b0); #1;
    check_eq("lu_dest0", 32'(ctl_a), 32'(CTL_NONE));
    tick();
    set_in(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 4'h0, 1'b0); #1;
    check_eq("lu_src2_two", 32'(ctl_a), 32'(CTL_LU));
    tick();
    check_eq("lu_cnt2", 32'(a_if.stall_cnt), 32'd2);

    // 3. taken branch overrides load-use.
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 1'b1); #1;
    check_eq("br_over_lu", 32'(ctl_a), 32'(CTL_BR));
    tick();
    check_eq("br_cnt", 32'(a_if.stall_cnt), 32'd2);

    // 4/5. multicycle op: 3 hold cycles (branch and load-use ignored), release, then a second op.
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 4'hE, 1'b0); #1;
    check_eq("mc1_h1", 32'(ctl_a), 32'(CTL_HOLD));
    check_eq("mclat1_none", 32'(ctl_c), 32'(CTL_NONE));
    tick();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 4'hE, 1'b1); #1;
    check_eq("mc1_h2_br", 32'(ctl_a), 32'(CTL_HOLD));
    tick();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 4'hE, 1'b0); #1;
    check_eq("mc1_h3_lu", 32'(ctl_a), 32'(CTL_HOLD));
    tick();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 4'hE, 1'b0); #1;
    check_eq("mc1_release", 32'(ctl_a), 32'(CTL_NONE));
    check_eq("mc1_cnt", 32'(a_if.stall_cnt), 32'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("mc2_h%0d", i + 1), 32'(ctl_a), 32'(CTL_HOLD));
      tick();
    end
    #1;
    check_eq("mc2_release", 32'(ctl_a), 32'(CTL_NONE));
    check_eq("mc2_cnt", 32'(a_if.stall_cnt), 32'd8);
    check_eq("sat_cnt_mc", 32'(b_if.stall_cnt), 32'd3);
    tick();

    // 6. asynchronous reset in the middle of a multicycle op.
    tick();
    #1;
    check_eq("mc3_busy", 32'(ctl_a), 32'(CTL_HOLD));
    rst_n = 1'b0; #1;
    check_eq("rst_mid_ctl", 32'(ctl_a), 32'(CTL_NONE));
    check_eq("rst_mid_cnt", 32'(a_if.stall_cnt), 32'd0);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 4'h0, 1'b0);
    tick();
    rst_n = 1'b1; #1;
    check_eq("rst_resume_run", 32'(ctl_a), 32'(CTL_NONE));
    tick();

    // Five load-use stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      set_in(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 4'h0, 1'b0); #1;
      check_eq($sformatf("sat_lu%0d", i), 32'(ctl_a), 32'(CTL_LU));
      tick();
    end
    check_eq("cnt_after5", 32'(a_if.stall_cnt), 32'd5);
    check_eq("sat_cnt", 32'(b_if.stall_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
